period_meter: RTL and testbench

//   Measures the spacing, in clk cycles, between rising edges of a pulse stream.
//   It is the receiving end of the time_mode tick generator: time_mode turns a

---
 rtl/period_meter.sv | 107 ++++++++++
 tb/tb_period_meter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Measures the rising-edge-to-rising-edge spacing of a synchronous pulse stream
// in clk cycles, with overflow detection and a lock indicator for stable periods.
module period_meter #(
  parameter int unsigned WIDTH    = 27,
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             meas_en,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             overflow,
  output logic             locked
);

  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam logic [MATCH_W-1:0] LOCK_M = MATCH_W'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   cnt, cnt_nx;
  logic [WIDTH-1:0]   period_nx;
  logic [MATCH_W-1:0] match, match_nx;
  logic               pulse_q;
  logic               edge_det;
  logic               valid_nx, ovf_nx, locked_nx;

  assign edge_det = pulse_in & ~pulse_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pulse_q      <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      locked       <= 1'b0;
      match        <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      pulse_q      <= pulse_in;
      period       <= period_nx;
      period_valid <= valid_nx;
      overflow     <= ovf_nx;
      locked       <= locked_nx;
      match        <= match_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    period_nx = period;
    valid_nx  = 1'b0;
    ovf_nx    = 1'b0;
    match_nx  = match;
    locked_nx = locked;
    // Disable wins over any edge or overflow in the same cycle.
    if (!meas_en) begin
      state_nx  = IDLE;
      cnt_nx    = '0;
      match_nx  = '0;
      locked_nx = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nx   = '0;
          state_nx = ARM;
        end
        ARM: begin
          if (edge_det) begin
            cnt_nx   = WIDTH'(1);
            state_nx = MEASURE;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            period_nx = cnt;
            valid_nx  = 1'b1;
            cnt_nx    = WIDTH'(1);
            // match==0 means no reference period since the last arm.
            if (match != '0 && cnt == period) begin
              if (match < LOCK_M) match_nx = match + 1'b1;
            end else begin
              match_nx = MATCH_W'(1);
            end
            locked_nx = (match_nx >= LOCK_M);
          end else if (cnt == '1) begin
            ovf_nx    = 1'b1;
            state_nx  = ARM;
            cnt_nx    = '0;
            match_nx  = '0;
            locked_nx = 1'b0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: edge-timestamp reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_period_meter;
  localparam int unsigned W    = 5;
  localparam int unsigned LOCK = 3;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         meas_en = 1'b0;
  logic         pulse_in = 1'b0;
  logic [W-1:0] period;
  logic         period_valid, overflow, locked;

  int checks = 0;
  int failures = 0;

  period_meter #(.WIDTH(W), .LOCK_CNT(LOCK)) dut (
    .clk(clk), .rst(rst), .meas_en(meas_en), .pulse_in(pulse_in),
    .period(period), .period_valid(period_valid),
    .overflow(overflow), .locked(locked)
  );

  always #5 clk = ~clk;

  // Reference model: timestamps of rising edges and a history of measured periods.
  int  t = 0;
  int  t_ref = 0;
  bit  have_ref, en_prev, p_prev;
  int  hist[$];
  int  m_period;
  bit  m_valid, m_ovf, m_locked;

  function automatic bit lock_fn();
    if (hist.size() < LOCK) return 1'b0;
    for (int i = 1; i < LOCK; i++)
      if (hist[hist.size()-1-i] != hist[hist.size()-1]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      en_prev = 0; p_prev = 0; have_ref = 0; hist.delete();
      m_period = 0; m_valid = 0; m_ovf = 0; m_locked = 0;
    end else begin
      bit rise_now;
      rise_now = pulse_in && !p_prev;
      m_valid = 0;
      m_ovf = 0;
      if (!meas_en) begin
        have_ref = 0; hist.delete(); m_locked = 0;
      end else if (en_prev) begin
        if (rise_now) begin
          if (have_ref) begin
            m_period = t - t_ref;
            m_valid = 1;
            hist.push_back(m_period);
            m_locked = lock_fn();
          end
          have_ref = 1;
          t_ref = t;
        end else if (have_ref && (t - t_ref) == MAXC) begin
          m_ovf = 1; have_ref = 0; hist.delete(); m_locked = 0;
        end
      end
      en_prev = meas_en;
      p_prev = pulse_in;
      t++;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (int'(period) != m_period || period_valid != m_valid ||
        overflow != m_ovf || locked != m_locked) begin
      failures++;
      $display("FAIL model t=%0d: period=%0d valid=%0b ovf=%0b locked=%0b, required period=%0d valid=%0b ovf=%0b locked=%0b",
               t, period, period_valid, overflow, locked, m_period, m_valid, m_ovf, m_locked);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rise();
    pulse_in = 1'b1;
    tick();
  endtask

  task automatic rest(input int spacing, input int hi);
    for (int i = 1; i < spacing; i++) begin
      pulse_in = (i < hi);
      tick();
    end
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_period", int'(period), 0);
    chk("reset_locked", int'(locked), 0);

    // 20-cycle single-cycle pulses, lock after the 4th edge
    meas_en = 1'b1;
    tick();
    rise();
    chk("first_edge_no_strobe", int'(period_valid), 0);
    rest(20, 1);
    rise();
    chk("p20_valid", int'(period_valid), 1);
    chk("p20_period", int'(period), 20);
    chk("p20_unlocked", int'(locked), 0);
    rest(20, 1);
    rise();
    rest(20, 1);
    rise();
    chk("p20_locked", int'(locked), 1);
    rest(20, 1);

    // wide pulses, edges 10 apart, then spacing 12
    for (int k = 0; k < 4; k++) begin
      rise();
      rest(10, 5);
    end
    chk("p10_period", int'(period), 10);
    chk("p10_locked", int'(locked), 1);
    rise();
    rest(12, 5);
    rise();
    chk("p12_valid", int'(period_valid), 1);
    chk("p12_period", int'(period), 12);
    chk("p12_unlock", int'(locked), 0);

    // silence -> overflow 31 cycles after the edge
    pulse_in = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i == 30) chk("ovf_not_early", int'(overflow), 0);
      if (i == 31) begin
        chk("ovf_strobe", int'(overflow), 1);
        chk("ovf_period_kept", int'(period), 12);
      end
    end
    tick();
    chk("ovf_one_cycle", int'(overflow), 0);
    rise();
    chk("rearm_no_strobe", int'(period_valid), 0);
    rest(15, 1);
    rise();
    chk("p15_period", int'(period), 15);
    rest(31, 1);
    rise();
    chk("p31_valid", int'(period_valid), 1);
    chk("p31_period", int'(period), 31);

    // lock at 8, disable for 3 cycles, re-enable
    rest(8, 1);
    for (int k = 0; k < 3; k++) begin
      rise();
      if (k == 2) chk("p8_locked", int'(locked), 1);
      rest(8, 1);
    end
    meas_en = 1'b0;
    repeat (3) tick();
    chk("dis_unlocked", int'(locked), 0);
    chk("dis_period_kept", int'(period), 8);
    meas_en = 1'b1;
    tick();
    rise();
    chk("reen_first_no_strobe", int'(period_valid), 0);
    rest(9, 1);
    rise();
    chk("reen_p9_valid", int'(period_valid), 1);
    chk("reen_p9_period", int'(period), 9);

    // edge coincides with meas_en falling
    rest(9, 1);
    pulse_in = 1'b1;
    meas_en = 1'b0;
    tick();
    chk("edge_at_disable", int'(period_valid), 0);
    pulse_in = 1'b0;
    tick();

    // asynchronous reset mid-measurement
    meas_en = 1'b1;
    tick();
    rise();
    pulse_in = 1'b0;
    repeat (9) tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_period", int'(period), 0);
    chk("async_rst_flags", int'({period_valid, overflow, locked}), 0);
    meas_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // randomized bursts of fixed spacing with occasional disable
    meas_en = 1'b1;
    for (int b = 0; b < 60; b++) begin
      int sp, hi, reps;
      sp   = $urandom_range(2, 40);
      hi   = $urandom_range(1, sp - 1);
      reps = $urandom_range(1, 6);
      for (int r = 0; r < reps; r++)
        for (int i = 0; i < sp; i++) begin
          pulse_in = (i < hi);
          meas_en  = ($urandom_range(0, 299) != 0);
          tick();
        end
    end
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
